// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared defaults, FSM encoding and bit-counter sizing for the SPI target
package spi_slave_pkg;
  localparam int DEF_DATA_W = 32;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with rise/fall pulses (clk, rst_n, d in; rise, fall out)
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q;
  logic prev_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end
  assign rise = sync_q[STAGES-1] & ~prev_q;
  assign fall = ~sync_q[STAGES-1] & prev_q;
endmodule

// File: rtl/spi_slave_controller.sv
// spi_slave_controller: SPI mode-0 target, MSB first, with TX/RX valid-ready streams
// pins: sclk_i/cs_n_i/sdi_i in, sdo_o out; tx stream: tx_data_i/tx_data_vld_i/tx_data_rdy_o;
// rx stream: rx_data_o/rx_data_vld_o/rx_data_rdy_i; pulses: eot_o, tx_udf_o, rx_ovf_o
module spi_slave_controller
  import spi_slave_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              pclk_i,
  input  logic              prst_n_i,
  input  logic              sclk_i,
  input  logic              cs_n_i,
  input  logic              sdi_i,
  output logic              sdo_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_data_vld_i,
  output logic              tx_data_rdy_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_data_vld_o,
  input  logic              rx_data_rdy_i,
  output logic              eot_o,
  output logic              tx_udf_o,
  output logic              rx_ovf_o
);
  localparam int CW = cnt_w(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] FULL = CW'(DATA_W);
  state_e state_q, state_d;
  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] sdi_q;
  logic sdi_s;
  logic [DATA_W-1:0] hold_q, shift_tx, shift_rx, tx_word;
  logic hold_full, accept, done_q;
  logic [CW-1:0] bit_cnt;
  logic start, active, stop, sck_up, sck_dn, reload, word_done;
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(pclk_i), .rst_n(prst_n_i), .d(sclk_i), .rise(sck_rise), .fall(sck_fall)
  );
  // cs_n idles high, so its synchronizer resets high to avoid a phantom select
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(pclk_i), .rst_n(prst_n_i), .d(cs_n_i), .rise(cs_rise), .fall(cs_fall)
  );
  // sdi gets the same depth as sclk so data lines up with the sclk edge pulse
  assign sdi_s = sdi_q[SYNC_STAGES-1];
  assign tx_data_rdy_o = ~hold_full;
  assign accept = tx_data_vld_i & ~hold_full;
  assign tx_word = hold_full ? hold_q : '0;
  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb state_d = state_q == IDLE ? (cs_fall ? SHIFT : IDLE) : (cs_rise ? IDLE : SHIFT);
  // cs_n rise masks any sclk edge seen in the same cycle
  always_comb begin
    start = state_q == IDLE && cs_fall;
    active = state_q == SHIFT && !cs_rise;
    stop = state_q == SHIFT && cs_rise;
    sck_up = active && sck_rise;
    sck_dn = active && sck_fall;
    reload = start || (sck_dn && bit_cnt == FULL);
    word_done = sck_up && bit_cnt == LAST;
  end
  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      sdi_q <= '0;
      hold_q <= '0;
      hold_full <= 1'b0;
      shift_tx <= '0;
      shift_rx <= '0;
      bit_cnt <= '0;
      sdo_o <= 1'b0;
      done_q <= 1'b0;
      rx_data_o <= '0;
      rx_data_vld_o <= 1'b0;
      eot_o <= 1'b0;
      tx_udf_o <= 1'b0;
      rx_ovf_o <= 1'b0;
    end else begin
      sdi_q <= {sdi_q[SYNC_STAGES-2:0], sdi_i};
      if (accept) hold_q <= tx_data_i;
      hold_full <= accept || (hold_full && !reload);
      tx_udf_o <= reload && !hold_full;
      eot_o <= stop;
      done_q <= word_done;
      shift_tx <= reload ? tx_word : sck_dn ? shift_tx << 1 : shift_tx;
      sdo_o <= reload ? tx_word[DATA_W-1] : sck_dn ? shift_tx[DATA_W-2] : stop ? 1'b0 : sdo_o;
      shift_rx <= sck_up ? {shift_rx[DATA_W-2:0], sdi_s} : shift_rx;
      bit_cnt <= reload ? '0 : sck_up ? bit_cnt + 1'b1 : bit_cnt;
      // a full, unconsumed RX register keeps its word and the new one is dropped
      rx_ovf_o <= done_q && rx_data_vld_o && !rx_data_rdy_i;
      if (done_q && !(rx_data_vld_o && !rx_data_rdy_i)) rx_data_o <= shift_rx;
      rx_data_vld_o <= done_q || (rx_data_vld_o && !rx_data_rdy_i);
    end
  end
endmodule

// File: tb/tb_spi_slave_controller.sv
// tb_spi_slave_controller: table-driven and scoreboarded checks of the SPI mode-0 target
module tb_spi_slave_controller;
  logic pclk = 1'b0, prst_n = 1'b0, sclk = 1'b0, cs_n = 1'b1, sdi = 1'b0;
  logic tx_vld = 1'b0, rx_rdy = 1'b1;
  logic [31:0] tx_data = '0;
  logic sdo, tx_rdy, rx_vld, eot, udf, ovf;
  logic [31:0] rx_data;
  int n_vec = 0, n_err = 0, n_eot = 0, n_udf = 0, n_ovf = 0, n_pop = 0;
  logic [31:0] sb[$];
  typedef struct {
    logic        pre;
    logic [31:0] tx;
    logic [31:0] mosi;
    logic [31:0] miso;
    int          udf;
  } vec_t;
  vec_t tbl[5];
  spi_slave_controller #(.DATA_W(32), .SYNC_STAGES(2)) dut (
    .pclk_i(pclk), .prst_n_i(prst_n), .sclk_i(sclk), .cs_n_i(cs_n), .sdi_i(sdi),
    .sdo_o(sdo), .tx_data_i(tx_data), .tx_data_vld_i(tx_vld), .tx_data_rdy_o(tx_rdy),
    .rx_data_o(rx_data), .rx_data_vld_o(rx_vld), .rx_data_rdy_i(rx_rdy),
    .eot_o(eot), .tx_udf_o(udf), .rx_ovf_o(ovf)
  );
  always #5 pclk = ~pclk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask
  always @(negedge pclk) begin
    if (prst_n) begin
      n_eot += int'(eot);
      n_udf += int'(udf);
      n_ovf += int'(ovf);
      if (rx_vld && rx_rdy) begin
        n_pop++;
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rx_unexpected: got %h, want no word", rx_data);
        end else chk("rx_word", rx_data, sb.pop_front());
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask
  task automatic load_tx(input logic [31:0] w);
    int i;
    i = 0;
    while (!tx_rdy && i < 400) begin
      tick(1);
      i++;
    end
    chk("tx_rdy_wait", 32'(tx_rdy), 32'd1);
    tx_data = w;
    tx_vld = 1'b1;
    tick(1);
    tx_vld = 1'b0;
    chk("tx_rdy_clear", 32'(tx_rdy), 32'd0);
  endtask
  task automatic xfer(input logic [31:0] mosi, input int nbits, output logic [31:0] miso);
    miso = '0;
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      sdi = mosi[31-i];
      tick(4);
      sclk = 1'b1;
      miso = {miso[30:0], sdo};
      tick(4);
    end
  endtask
  task automatic cs_start();
    cs_n = 1'b0;
    tick(4);
  endtask
  // sclk fall coincides with cs_n rise, so the final fall never reloads TX
  task automatic cs_end();
    sclk = 1'b0;
    cs_n = 1'b1;
    tick(8);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, 32'({sdo, tx_rdy, rx_vld, eot, udf, ovf}), 32'b010000);
    chk({tag, "_rx_data"}, rx_data, 32'h0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] m1, m2;
    int u0, e0, o0, p0;
    tbl[0] = '{1'b1, 32'hA5A5_0F0F, 32'h1234_5678, 32'hA5A5_0F0F, 0};
    tbl[1] = '{1'b0, 32'h0000_0000, 32'hCAFE_F00D, 32'h0000_0000, 1};
    tbl[2] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 0};
    tbl[3] = '{1'b1, 32'h8000_0001, 32'hFFFF_FFFF, 32'h8000_0001, 0};
    tbl[4] = '{1'b1, 32'h0000_0000, 32'h8000_0001, 32'h0000_0000, 0};
    tick(3);
    chk_reset("rst_hold");
    prst_n = 1'b1;
    tick(3);
    chk_reset("rst_rel");
    for (int k = 0; k < 5; k++) begin
      u0 = n_udf;
      e0 = n_eot;
      if (tbl[k].pre) load_tx(tbl[k].tx);
      sb.push_back(tbl[k].mosi);
      cs_start();
      xfer(tbl[k].mosi, 32, m1);
      cs_end();
      chk($sformatf("v%0d_miso", k), m1, tbl[k].miso);
      chk($sformatf("v%0d_udf", k), 32'(n_udf - u0), 32'(tbl[k].udf));
      chk($sformatf("v%0d_eot", k), 32'(n_eot - e0), 32'd1);
      chk($sformatf("v%0d_drain", k), 32'(sb.size()), 32'd0);
    end
    u0 = n_udf;
    e0 = n_eot;
    load_tx(32'h1111_2222);
    sb.push_back(32'h0F1E_2D3C);
    sb.push_back(32'hC3D2_E1F0);
    cs_start();
    load_tx(32'h3333_4444);
    xfer(32'h0F1E_2D3C, 32, m1);
    xfer(32'hC3D2_E1F0, 32, m2);
    cs_end();
    chk("two_miso0", m1, 32'h1111_2222);
    chk("two_miso1", m2, 32'h3333_4444);
    chk("two_udf", 32'(n_udf - u0), 32'd0);
    chk("two_eot", 32'(n_eot - e0), 32'd1);
    chk("two_drain", 32'(sb.size()), 32'd0);
    rx_rdy = 1'b0;
    o0 = n_ovf;
    load_tx(32'h5555_0000);
    cs_start();
    load_tx(32'h6666_0000);
    xfer(32'hAAAA_0001, 32, m1);
    xfer(32'hBBBB_0002, 32, m2);
    cs_end();
    chk("ovf_keep", rx_data, 32'hAAAA_0001);
    chk("ovf_vld", 32'(rx_vld), 32'd1);
    chk("ovf_pulse", 32'(n_ovf - o0), 32'd1);
    sb.push_back(32'hAAAA_0001);
    rx_rdy = 1'b1;
    tick(1);
    chk("ovf_vld_drop", 32'(rx_vld), 32'd0);
    chk("ovf_drain", 32'(sb.size()), 32'd0);
    e0 = n_eot;
    u0 = n_udf;
    p0 = n_pop;
    load_tx(32'h7777_0000);
    cs_start();
    xfer(32'hFEDC_BA98, 13, m1);
    cs_end();
    chk("part_eot", 32'(n_eot - e0), 32'd1);
    chk("part_udf", 32'(n_udf - u0), 32'd0);
    chk("part_nopop", 32'(n_pop - p0), 32'd0);
    chk("part_vld", 32'(rx_vld), 32'd0);
    load_tx(32'h5A5A_5A5A);
    sb.push_back(32'h1357_9BDF);
    cs_start();
    xfer(32'h1357_9BDF, 32, m1);
    cs_end();
    chk("part_next_miso", m1, 32'h5A5A_5A5A);
    chk("part_next_drain", 32'(sb.size()), 32'd0);
    load_tx(32'h7777_8888);
    cs_start();
    load_tx(32'h9999_AAAA);
    xfer(32'h0123_4567, 10, m1);
    prst_n = 1'b0;
    #1;
    chk_reset("mid_rst");
    sclk = 1'b0;
    cs_n = 1'b1;
    tick(3);
    prst_n = 1'b1;
    tick(5);
    chk_reset("mid_rel");
    load_tx(32'h600D_F00D);
    sb.push_back(32'hDEAD_BEEF);
    cs_start();
    xfer(32'hDEAD_BEEF, 32, m1);
    cs_end();
    chk("post_rst_miso", m1, 32'h600D_F00D);
    chk("post_rst_rx", rx_data, 32'hDEAD_BEEF);
    chk("post_rst_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
